// File: rtl/tetris_cmd_issuer.sv
// tetris_cmd_issuer: turns button events, gravity ticks and garbage-bar
// requests into single engine commands. At most one command is issued per
// WAIT visit of the engine.
//
// Engine state / command encoding (4 bits)
//   code | name       | meaning
//   0    | NONE       | no command (ctrl idle value)
//   1    | INIT       | engine before first game
//   2    | WAIT       | engine ready to accept a command
//   3    | GEN        | engine spawning a new piece
//   4    | END        | game over
//   5    | BAR        | insert garbage row (uses bar_mask)
//   6    | DOWN       | soft drop / gravity step / start token
//   7    | LEFT       | move left
//   8    | RIGHT      | move right
//   9    | ROTATE     | rotate clockwise
//   10   | ROTATE_REV | rotate counter-clockwise
//   11   | HOLD       | swap with hold piece
//   12   | DROP       | hard drop
module tetris_cmd_issuer #(
    parameter int DEPTH       = 4,
    parameter int BASE_PERIOD = 50_000_000,
    parameter int LEVEL_STEP  = 4_000_000,
    parameter int MIN_PERIOD  = 5_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] btn,
    input  logic [3:0] level,
    input  logic       bar_req,
    input  logic [9:0] bar_in,
    input  logic [3:0] state,
    output logic [3:0] ctrl,
    output logic [9:0] bar_mask,
    output logic [7:0] drop_cnt
);

    localparam logic [3:0] C_NONE       = 4'd0;
    localparam logic [3:0] C_INIT       = 4'd1;
    localparam logic [3:0] C_WAIT       = 4'd2;
    localparam logic [3:0] C_GEN        = 4'd3;
    localparam logic [3:0] C_END        = 4'd4;
    localparam logic [3:0] C_BAR        = 4'd5;
    localparam logic [3:0] C_DOWN       = 4'd6;
    localparam logic [3:0] C_LEFT       = 4'd7;
    localparam logic [3:0] C_RIGHT      = 4'd8;
    localparam logic [3:0] C_ROTATE     = 4'd9;
    localparam logic [3:0] C_ROTATE_REV = 4'd10;
    localparam logic [3:0] C_HOLD       = 4'd11;
    localparam logic [3:0] C_DROP       = 4'd12;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3:0]    r_ctrl;
    logic [9:0]    r_bar_mask;
    logic [7:0]    r_drop_cnt;
    logic          r_armed;
    logic          r_bar_pend;
    logic [9:0]    r_bar_buf;
    logic          r_grav_pend;
    logic [31:0]   r_grav_cnt;
    logic [3:0]    r_fifo [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_idle_st;
    logic          w_start;
    logic          w_can_issue;
    logic          w_iss_bar;
    logic          w_iss_grav;
    logic          w_iss_fifo;
    logic          w_fifo_full;
    logic          w_fifo_nempty;
    logic          w_enq_req;
    logic          w_push;
    logic          w_flush;
    logic [3:0]    w_btn_cmd;
    logic [3:0]    w_nset;
    logic [3:0]    w_drop_inc;
    logic [8:0]    w_drop_sum;
    logic [31:0]   w_step;
    logic [31:0]   w_period_m1;

    assign ctrl     = r_ctrl;
    assign bar_mask = r_bar_mask;
    assign drop_cnt = r_drop_cnt;

    // Gravity period: BASE - level*STEP, floored at MIN (compared without underflow).
    always_comb begin
        w_step = 32'(level) * 32'(LEVEL_STEP);
        if (w_step + 32'(MIN_PERIOD) >= 32'(BASE_PERIOD))
            w_period_m1 = 32'(MIN_PERIOD) - 32'd1;
        else
            w_period_m1 = 32'(BASE_PERIOD) - w_step - 32'd1;
    end

    // Issue selection, enqueue decision and drop accounting for this cycle.
    always_comb begin
        w_idle_st     = (state == C_INIT) || (state == C_END);
        w_start       = w_idle_st && ((|btn) || bar_req);
        w_fifo_full   = (r_count == (AW+1)'(DEPTH));
        w_fifo_nempty = (r_count != '0);
        w_can_issue   = (state == C_WAIT) && r_armed;
        w_iss_bar     = w_can_issue && r_bar_pend;
        w_iss_grav    = w_can_issue && !r_bar_pend && r_grav_pend;
        w_iss_fifo    = w_can_issue && !r_bar_pend && !r_grav_pend && w_fifo_nempty;
        w_enq_req     = (|btn) && !w_idle_st;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        w_push        = w_enq_req && (!w_fifo_full || w_iss_fifo);
        // END entry flushes the queue; while in END nothing is enqueued anyway.
        w_flush       = w_start || (state == C_END);

        w_btn_cmd = C_NONE;
        if (btn[6])      w_btn_cmd = C_DROP;
        else if (btn[5]) w_btn_cmd = C_HOLD;
        else if (btn[4]) w_btn_cmd = C_ROTATE;
        else if (btn[3]) w_btn_cmd = C_ROTATE_REV;
        else if (btn[2]) w_btn_cmd = C_LEFT;
        else if (btn[1]) w_btn_cmd = C_RIGHT;
        else if (btn[0]) w_btn_cmd = C_DOWN;

        w_nset = '0;
        for (int i = 0; i < 7; i++)
            w_nset = w_nset + {3'b000, btn[i]};

        w_drop_inc = '0;
        if (w_enq_req) begin
            w_drop_inc = w_nset - 4'd1;
            if (!w_push)
                w_drop_inc = w_drop_inc + 4'd1;
        end
        if (bar_req && r_bar_pend && !w_idle_st)
            w_drop_inc = w_drop_inc + 4'd1;
        w_drop_sum = {1'b0, r_drop_cnt} + {5'b00000, w_drop_inc};
    end

    // Button FIFO storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= w_btn_cmd;
    end

    // Button FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_iss_fifo)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_iss_fifo)
                r_count <= r_count + (AW+1)'(1);
            else if (!w_push && w_iss_fifo)
                r_count <= r_count - (AW+1)'(1);
        end
    end

    // Gravity counter; a new tick is recorded even in the cycle the old one is consumed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_grav_cnt  <= '0;
            r_grav_pend <= 1'b0;
        end else if (w_start) begin
            r_grav_pend <= 1'b0;
        end else begin
            if (w_iss_grav)
                r_grav_pend <= 1'b0;
            if (!w_idle_st) begin
                if (state == C_GEN) begin
                    r_grav_cnt <= '0;
                end else if (r_grav_cnt >= w_period_m1) begin
                    r_grav_cnt  <= '0;
                    r_grav_pend <= 1'b1;
                end else begin
                    r_grav_cnt <= r_grav_cnt + 32'd1;
                end
            end
        end
    end

    // Garbage-bar request capture; only one request may be outstanding.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_bar_pend <= 1'b0;
            r_bar_buf  <= '0;
        end else if (w_start) begin
            r_bar_pend <= 1'b0;
        end else begin
            if (w_iss_bar)
                r_bar_pend <= 1'b0;
            if (bar_req && !r_bar_pend && !w_idle_st) begin
                r_bar_buf  <= bar_in;
                r_bar_pend <= 1'b1;
            end
        end
    end

    // Registered command output, bar mask, arming and drop counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ctrl     <= C_NONE;
            r_bar_mask <= '0;
            r_drop_cnt <= '0;
            r_armed    <= 1'b1;
        end else begin
            r_ctrl <= C_NONE;
            if (w_start)
                r_ctrl <= C_DOWN;
            else if (w_iss_bar)
                r_ctrl <= C_BAR;
            else if (w_iss_grav)
                r_ctrl <= C_DOWN;
            else if (w_iss_fifo)
                r_ctrl <= r_fifo[r_rd_ptr];

            // The mask must survive the issue cycle (still WAIT, armed low),
            // so it is only cleared once the engine has left and come back.
            if (w_iss_bar)
                r_bar_mask <= r_bar_buf;
            else if ((state == C_WAIT) && r_armed)
                r_bar_mask <= '0;

            if (state != C_WAIT)
                r_armed <= 1'b1;
            else if (w_iss_bar || w_iss_grav || w_iss_fifo)
                r_armed <= 1'b0;

            r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

endmodule

// File: tb/tb_tetris_cmd_issuer.sv
// Directed bench for tetris_cmd_issuer: issue timing, priority, FIFO depth,
// gravity period/clear, garbage bar, start tokens, saturation and reset.
module tb_tetris_cmd_issuer;

    localparam logic [3:0] C_NONE  = 4'd0;
    localparam logic [3:0] C_WAIT  = 4'd2;
    localparam logic [3:0] C_GEN   = 4'd3;
    localparam logic [3:0] C_END   = 4'd4;
    localparam logic [3:0] C_BAR   = 4'd5;
    localparam logic [3:0] C_DOWN  = 4'd6;
    localparam logic [3:0] C_LEFT  = 4'd7;
    localparam logic [3:0] C_RIGHT = 4'd8;
    localparam logic [3:0] C_DROP  = 4'd12;

    logic       clk;
    logic       reset_n;
    logic [6:0] btn;
    logic [3:0] level;
    logic       bar_req;
    logic [9:0] bar_in;
    logic [3:0] st;
    logic [3:0] ctrl;
    logic [9:0] bar_mask;
    logic [7:0] drop_cnt;
    logic [3:0] g_ctrl;
    logic [9:0] g_bar_mask;
    logic [7:0] g_drop_cnt;

    int n_chk;
    int n_fail;
    int n_cyc;

    tetris_cmd_issuer #(.DEPTH(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .btn(btn), .level(level),
        .bar_req(bar_req), .bar_in(bar_in), .state(st),
        .ctrl(ctrl), .bar_mask(bar_mask), .drop_cnt(drop_cnt)
    );

    tetris_cmd_issuer #(.DEPTH(4), .BASE_PERIOD(10), .LEVEL_STEP(3), .MIN_PERIOD(5)) u_grav (
        .clk(clk), .reset_n(reset_n), .btn(btn), .level(level),
        .bar_req(bar_req), .bar_in(bar_in), .state(st),
        .ctrl(g_ctrl), .bar_mask(g_bar_mask), .drop_cnt(g_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        btn = '0;
        level = 4'd3;
        bar_req = 1'b0;
        bar_in = '0;
        st = C_WAIT;
        do_reset();

        chk("rst_ctrl", 32'(ctrl), 32'(C_NONE));
        chk("rst_mask", 32'(bar_mask), 32'h0);
        chk("rst_drop", 32'(drop_cnt), 32'h0);

        // Gravity: period = max(10 - 3*3, 5) = 5 -> pend at 5th edge, DOWN at 6th.
        n_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cyc++;
            if (g_ctrl == C_DOWN) break;
        end
        chk("grav_first", 32'(n_cyc), 32'd6);
        st = C_GEN;
        repeat (3) begin
            tick();
            chk("grav_gen_quiet", 32'(g_ctrl), 32'(C_NONE));
        end
        st = C_WAIT;
        n_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cyc++;
            if (g_ctrl == C_DOWN) break;
        end
        chk("grav_after_gen", 32'(n_cyc), 32'd6);
        st = C_DOWN;
        tick();
        st = C_WAIT;
        n_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cyc++;
            if (g_ctrl == C_DOWN) break;
        end
        chk("grav_next_visit", 32'(n_cyc), 32'd4);

        // Single LEFT: enqueue edge, then issue edge, then one cycle only.
        st = C_WAIT;
        do_reset();
        btn = 7'b0000100;
        tick();
        btn = '0;
        chk("left_lat0", 32'(ctrl), 32'(C_NONE));
        tick();
        chk("left_issue", 32'(ctrl), 32'(C_LEFT));
        tick();
        chk("left_once", 32'(ctrl), 32'(C_NONE));
        st = C_LEFT;
        tick();
        st = C_WAIT;
        tick();
        chk("left_fifo_empty", 32'(ctrl), 32'(C_NONE));

        // Multi-bit press: DROP wins, LEFT and DOWN are dropped.
        btn = 7'b1000101;
        tick();
        btn = '0;
        chk("prio_drop_cnt", 32'(drop_cnt), 32'd2);
        tick();
        chk("prio_issue", 32'(ctrl), 32'(C_DROP));
        st = C_LEFT;
        tick();
        st = C_WAIT;
        tick();
        chk("prio_only_one_a", 32'(ctrl), 32'(C_NONE));
        tick();
        chk("prio_only_one_b", 32'(ctrl), 32'(C_NONE));

        // Five LEFTs into a depth-4 FIFO outside WAIT.
        st = C_GEN;
        repeat (5) begin
            btn = 7'b0000100;
            tick();
            btn = '0;
            tick();
        end
        chk("full_drop_cnt", 32'(drop_cnt), 32'd3);
        for (int v = 0; v < 4; v++) begin
            st = C_WAIT;
            tick();
            chk("visit_issue", 32'(ctrl), 32'(C_LEFT));
            tick();
            chk("visit_no_second_a", 32'(ctrl), 32'(C_NONE));
            tick();
            chk("visit_no_second_b", 32'(ctrl), 32'(C_NONE));
            st = C_GEN;
            tick();
        end
        st = C_WAIT;
        tick();
        chk("visit_fifo_drained", 32'(ctrl), 32'(C_NONE));

        // Garbage bar beats a queued RIGHT; second request while pending is dropped.
        st = C_GEN;
        btn = 7'b0000010;
        tick();
        btn = '0;
        bar_req = 1'b1;
        bar_in = 10'b0000010000;
        tick();
        bar_in = 10'h3FF;
        tick();
        bar_req = 1'b0;
        bar_in = '0;
        chk("bar_second_drop", 32'(drop_cnt), 32'd4);
        st = C_WAIT;
        tick();
        chk("bar_issue", 32'(ctrl), 32'(C_BAR));
        chk("bar_mask_issue", 32'(bar_mask), 32'h010);
        st = C_BAR;
        tick();
        chk("bar_mask_hold_a", 32'(bar_mask), 32'h010);
        chk("bar_ctrl_one_cycle", 32'(ctrl), 32'(C_NONE));
        tick();
        chk("bar_mask_hold_b", 32'(bar_mask), 32'h010);
        st = C_WAIT;
        tick();
        chk("bar_then_right", 32'(ctrl), 32'(C_RIGHT));
        chk("bar_mask_cleared", 32'(bar_mask), 32'h0);

        // Drop counter saturation with all buttons held outside WAIT.
        st = C_GEN;
        btn = 7'h7F;
        repeat (45) tick();
        btn = '0;
        chk("drop_saturate", 32'(drop_cnt), 32'd255);

        // END: start token, FIFO flushed, event not enqueued.
        st = C_END;
        tick();
        btn = 7'b0001000;
        tick();
        btn = '0;
        chk("end_token", 32'(ctrl), 32'(C_DOWN));
        tick();
        chk("end_token_once", 32'(ctrl), 32'(C_NONE));
        chk("end_drop_hold", 32'(drop_cnt), 32'd255);
        st = C_WAIT;
        repeat (3) begin
            tick();
            chk("end_no_enqueue", 32'(ctrl), 32'(C_NONE));
        end

        // Reset during an issue cycle.
        st = C_GEN;
        btn = 7'b0000100;
        tick();
        btn = '0;
        st = C_WAIT;
        tick();
        chk("rst_mid_issue", 32'(ctrl), 32'(C_LEFT));
        reset_n = 1'b0;
        tick();
        chk("rst_mid_ctrl", 32'(ctrl), 32'(C_NONE));
        chk("rst_mid_drop", 32'(drop_cnt), 32'd0);
        reset_n = 1'b1;
        repeat (2) begin
            tick();
            chk("rst_no_replay", 32'(ctrl), 32'(C_NONE));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
